serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor. Computes A - B - BorrowIn one bit per clock, LSB first.
- Instantiates the team's onebitfullsub cell as its arithmetic core and adds a registered borrow loop, operand shift registers, a bit counter and valid/ready handshakes.
- Sits directly downstream of operand producers and upstream of result consumers. It is the sequential wrapper the 1-bit full subtractor feeds.

Parameters:
- N, 8, operand/result width in bits (N >= 2).
- CW, $clog2(N+1), bit-counter width (derived, not user-set).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- InValid  input  1  operands present on A/B/BorrowIn.
- InReady  output  1  block can accept operands (high only in IDLE).
- A  input  N  minuend.
- B  input  N  subtrahend.
- BorrowIn  input  1  initial borrow into bit 0.
- OutValid  output  1  Diff/BorrowOut hold a completed result.
- OutReady  input  1  consumer accepts result.
- Diff  output  N  difference, A - B - BorrowIn mod 2^N.
- BorrowOut  output  1  borrow out of bit N-1 (1 when A < B + BorrowIn).
- Busy  output  1  high in RUN.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE; InReady=1; OutValid=0; Busy=0.
  - Diff=0; BorrowOut=0; internal A/B shift regs, borrow reg and counter all 0.
  - Applies from any state, including mid-RUN and DONE; a partial result is discarded.
- States:
  - IDLE: InReady=1. On an edge with InValid=1: load A_sh<=A, B_sh<=B, bor<=BorrowIn, cnt<=0, Diff reg<=0; go to RUN. If InValid=0, stay.
  - RUN: InReady=0, Busy=1. Each edge:
    - Feed A_sh[0], B_sh[0], bor to onebitfullsub. d = a^b^bor; bout = (~a&b) | (~(a^b)&bor).
    - A_sh, B_sh shift right with 0 fill.
    - Diff reg shifts right with d entering at bit N-1.
    - bor<=bout; cnt<=cnt+1.
    - On the edge where cnt==N-1 (the Nth bit): BorrowOut<=bout, go to DONE.
  - DONE: OutValid=1, Busy=0, InReady=0. Diff/BorrowOut stable. On an edge with OutReady=1: OutValid<=0, go to IDLE. Diff/BorrowOut keep their values until the next accept clears Diff.
- Latency:
  - The accept edge is E0. Bit operations occur on E1..EN.
  - OutValid is high after EN, i.e. N cycles after acceptance.
  - Minimum issue interval is N+2 cycles: accept, N bits, 1 DONE cycle with OutReady=1.
- Handshake rules:
  - InValid while not IDLE is ignored; no buffering. The producer must hold its operands until InReady&InValid.
  - OutReady while not DONE is ignored.
  - With OutReady held high, DONE lasts exactly one cycle.
  - With OutReady low, DONE holds indefinitely. This is backpressure, with no loss.
- No combinational path from A/B/InValid to any output. Diff, BorrowOut, OutValid, InReady and Busy are all registered or decoded from state only.
- Width rules:
  - Diff wraps modulo 2^N.
  - {BorrowOut, Diff} equals the (N+1)-bit two's-complement of A - B - BorrowIn.
- Simultaneous events:
  - rst_n low overrides InValid/OutReady.
  - InValid in DONE together with OutReady is not accepted that cycle; acceptance occurs earliest in the following IDLE cycle.

Test Plan:
- N=4, reset then A=5, B=3, BorrowIn=0, InValid pulse -> OutValid rises exactly 4 cycles after accept; Diff=4'h2, BorrowOut=0.
- N=4: A=3, B=5, Bin=0 -> Diff=4'hE, BorrowOut=1. A=0, B=0, Bin=1 -> Diff=4'hF, BorrowOut=1. A=F, B=F, Bin=1 -> Diff=4'hF, BorrowOut=1. A=F, B=0, Bin=0 -> Diff=4'hF, BorrowOut=0.
- N=4 exhaustive: all 512 (A, B, Bin) combos back-to-back with OutReady=1 -> every result matches {BorrowOut, Diff} = A-B-Bin (5-bit); accepts spaced exactly 6 cycles.
- Backpressure: OutReady=0 for 10 cycles in DONE -> OutValid, Diff, BorrowOut stable; InReady=0. Then OutReady=1 -> IDLE next edge, InReady=1.
- Protocol: InValid=1 with new operands during RUN -> ignored, in-flight result unchanged. OutReady=1 during RUN has no effect.
- Reset mid-op: rst_n=0 at bit 2 of 4 -> next cycle IDLE, all outputs 0, InReady=1. A fresh operation A=9, B=4, Bin=1 then yields Diff=4'h4, BorrowOut=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial N-bit subtractor (A - B - BorrowIn, LSB first) with valid/ready handshakes

module onebitfullsub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         InValid,
    output logic         InReady,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         BorrowIn,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [N-1:0] Diff,
    output logic         BorrowOut,
    output logic         Busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic          bor;
    logic [CW-1:0] cnt;
    logic [N-1:0]  diff_r;
    logic          borrow_out_r;
    logic          bit_d;
    logic          bit_bout;
    logic          last_bit;

    onebitfullsub u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bor),
        .d    (bit_d),
        .bout (bit_bout)
    );

    assign last_bit = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (InValid)  state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    if (OutReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operands shift out LSB first, difference shifts in from the MSB end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh         <= '0;
            b_sh         <= '0;
            bor          <= 1'b0;
            cnt          <= '0;
            diff_r       <= '0;
            borrow_out_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        bor    <= BorrowIn;
                        cnt    <= '0;
                        diff_r <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= {1'b0, a_sh[N-1:1]};
                    b_sh   <= {1'b0, b_sh[N-1:1]};
                    diff_r <= {bit_d, diff_r[N-1:1]};
                    bor    <= bit_bout;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        borrow_out_r <= bit_bout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign InReady   = (state == IDLE);
    assign Busy      = (state == RUN);
    assign OutValid  = (state == DONE);
    assign Diff      = diff_r;
    assign BorrowOut = borrow_out_r;
endmodule
